// File: rtl/npu_cfg_pkg.sv
// Shared definitions for the SSFR configuration path: loader state
// encoding, the SSFR reset value and the default frame sync marker.
package npu_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_LO  = 3'd1,
        ST_GET_HI  = 3'd2,
        ST_GET_CHK = 3'd3,
        ST_COMMIT  = 3'd4
    } loader_state_t;

    localparam logic [15:0] SSFR_RST_VAL  = 16'h2280;
    localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

    // Frame checksum: XOR of the sync marker and both payload bytes.
    function automatic logic [7:0] frame_chk(input logic [7:0] sync,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        return sync ^ lo ^ hi;
    endfunction

endpackage

// File: rtl/cfg_timeout_cnt.sv
// Clearable idle-cycle counter for the config loader. The terminal flag
// tells the loader that one more idle cycle would reach TIMEOUT_CYC, so a
// handshake arriving in that same cycle can still win over the timeout.
module cfg_timeout_cnt #(
    parameter int unsigned TO_W        = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] count;

    // Clear has priority over increment; the count otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TO_W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/ssfr_cfg_loader.sv
// Byte-stream frame parser feeding the 16-bit SSFR configuration register.
// Frames are SYNC, LO, HI, CHK; a good frame updates DA/DB and pulses
// EN_CONFIG, bad checksums and stalled frames raise sticky error flags.
module ssfr_cfg_loader
    import npu_cfg_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 16
) (
    input  logic       CLKEXT,
    input  logic       RST_N,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    input  logic       ERR_CLR,
    output logic [7:0] DA,
    output logic [7:0] DB,
    output logic       EN_CONFIG,
    output logic       BUSY,
    output logic       ERR_CHK,
    output logic       ERR_TO,
    output logic [7:0] CFG_CNT
);

    loader_state_t state;
    logic [7:0]    lo_q;
    logic [7:0]    hi_q;
    logic          hs;
    logic          in_get;
    logic          to_inc;
    logic          to_clr;
    logic          to_tc;
    logic          to_hit;

    assign DIN_READY = (state != ST_COMMIT);
    assign BUSY      = (state != ST_IDLE);
    assign hs        = DIN_VALID && DIN_READY;
    assign in_get    = (state == ST_GET_LO) || (state == ST_GET_HI) || (state == ST_GET_CHK);
    assign to_inc    = in_get && !hs;
    assign to_hit    = to_inc && to_tc;
    assign to_clr    = !in_get || hs || to_hit;

    cfg_timeout_cnt #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk   (CLKEXT),
        .rst_n (RST_N),
        .clr   (to_clr),
        .inc   (to_inc),
        .tc    (to_tc)
    );

    // Frame FSM and output registers. DA/DB/EN_CONFIG are loaded on the
    // CHK handshake so they are all visible together during the COMMIT cycle.
    // ERR_CLR is applied first so a same-cycle error set overrides it.
    always_ff @(posedge CLKEXT or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            DA        <= SSFR_RST_VAL[7:0];
            DB        <= SSFR_RST_VAL[15:8];
            EN_CONFIG <= 1'b0;
            ERR_CHK   <= 1'b0;
            ERR_TO    <= 1'b0;
            CFG_CNT   <= '0;
        end else begin
            EN_CONFIG <= 1'b0;
            if (ERR_CLR) begin
                ERR_CHK <= 1'b0;
                ERR_TO  <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (hs && (DIN == SYNC_BYTE)) begin
                        state <= ST_GET_LO;
                    end
                end
                ST_GET_LO: begin
                    if (hs) begin
                        lo_q  <= DIN;
                        state <= ST_GET_HI;
                    end else if (to_hit) begin
                        state  <= ST_IDLE;
                        ERR_TO <= 1'b1;
                    end
                end
                ST_GET_HI: begin
                    if (hs) begin
                        hi_q  <= DIN;
                        state <= ST_GET_CHK;
                    end else if (to_hit) begin
                        state  <= ST_IDLE;
                        ERR_TO <= 1'b1;
                    end
                end
                ST_GET_CHK: begin
                    if (hs) begin
                        if (DIN == frame_chk(SYNC_BYTE, lo_q, hi_q)) begin
                            state     <= ST_COMMIT;
                            DA        <= lo_q;
                            DB        <= hi_q;
                            EN_CONFIG <= 1'b1;
                            CFG_CNT   <= CFG_CNT + 8'd1;
                        end else begin
                            state   <= ST_IDLE;
                            ERR_CHK <= 1'b1;
                        end
                    end else if (to_hit) begin
                        state  <= ST_IDLE;
                        ERR_TO <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssfr_cfg_loader.sv
// Self-checking bench for ssfr_cfg_loader. A frame-level reference model
// (a queue of collected frame bytes plus an idle-cycle count) predicts the
// outputs after every clock edge; scenario tasks compare inline.
module tb_ssfr_cfg_loader;

    localparam int TO = 8;

    logic       CLKEXT = 1'b0;
    logic       RST_N  = 1'b0;
    logic [7:0] DIN    = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       ERR_CLR   = 1'b0;
    logic       DIN_READY;
    logic [7:0] DA;
    logic [7:0] DB;
    logic       EN_CONFIG;
    logic       BUSY;
    logic       ERR_CHK;
    logic       ERR_TO;
    logic [7:0] CFG_CNT;

    int n_compared = 0;
    int n_failed   = 0;

    // reference model state
    logic [7:0] exp_da;
    logic [7:0] exp_db;
    logic [7:0] exp_cnt;
    logic       exp_en;
    logic       exp_err_chk;
    logic       exp_err_to;
    bit         commit_now;
    logic [7:0] frame_q[$];
    int         idle_run;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       clr;
    } offer_t;

    ssfr_cfg_loader #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO),
        .TO_W        (16)
    ) dut (
        .CLKEXT    (CLKEXT),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .ERR_CLR   (ERR_CLR),
        .DA        (DA),
        .DB        (DB),
        .EN_CONFIG (EN_CONFIG),
        .BUSY      (BUSY),
        .ERR_CHK   (ERR_CHK),
        .ERR_TO    (ERR_TO),
        .CFG_CNT   (CFG_CNT)
    );

    always #5 CLKEXT = ~CLKEXT;

    function automatic logic exp_busy();
        return commit_now || (frame_q.size() != 0);
    endfunction

    function automatic logic exp_ready();
        return !commit_now;
    endfunction

    task automatic model_reset();
        exp_da      = 8'h80;
        exp_db      = 8'h22;
        exp_cnt     = 8'h00;
        exp_en      = 1'b0;
        exp_err_chk = 1'b0;
        exp_err_to  = 1'b0;
        commit_now  = 1'b0;
        frame_q.delete();
        idle_run    = 0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, return
    // whether the offered byte was transferred. Called at posedge+1.
    task automatic drive_cycle(input logic v, input logic [7:0] d,
                               input logic clr, output logic acc);
        bit chk_set;
        bit to_set;
        chk_set   = 1'b0;
        to_set    = 1'b0;
        DIN_VALID = v;
        DIN       = d;
        ERR_CLR   = clr;
        acc       = v && exp_ready();
        @(posedge CLKEXT);
        #1;
        exp_en = 1'b0;
        if (commit_now) begin
            commit_now = 1'b0;
        end else if (acc) begin
            idle_run = 0;
            if (frame_q.size() != 0 || d == 8'hA5) frame_q.push_back(d);
            if (frame_q.size() == 4) begin
                if ((frame_q[0] ^ frame_q[1] ^ frame_q[2]) == frame_q[3]) begin
                    exp_da     = frame_q[1];
                    exp_db     = frame_q[2];
                    exp_cnt    = exp_cnt + 8'd1;
                    exp_en     = 1'b1;
                    commit_now = 1'b1;
                end else begin
                    chk_set = 1'b1;
                end
                frame_q.delete();
            end
        end else if (frame_q.size() != 0) begin
            idle_run++;
            if (idle_run == TO) begin
                to_set   = 1'b1;
                idle_run = 0;
                frame_q.delete();
            end
        end
        exp_err_chk = chk_set ? 1'b1 : (clr ? 1'b0 : exp_err_chk);
        exp_err_to  = to_set  ? 1'b1 : (clr ? 1'b0 : exp_err_to);
    endtask

    task automatic drive_idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, acc);
    endtask

    // Offer a byte until it transfers; stalls only last through COMMIT.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int tries;
        tries = 0;
        do begin
            drive_cycle(1'b1, b, 1'b0, acc);
            tries++;
        end while (!acc && tries < 4);
        if (!acc) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL send_byte_stall byte=%h not accepted within %0d cycles", b, tries);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        DIN_VALID = 1'b0;
        ERR_CLR = 1'b0;
        repeat (3) @(posedge CLKEXT);
        #1;
        RST_N = 1'b1;
        model_reset();
        #2;
        n_compared += 8;
        if (DA !== 8'h80)      begin n_failed++; $display("[TB] FAIL reset_da got=%h exp=80", DA); end
        if (DB !== 8'h22)      begin n_failed++; $display("[TB] FAIL reset_db got=%h exp=22", DB); end
        if (EN_CONFIG !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_en got=%b exp=0", EN_CONFIG); end
        if (BUSY !== 1'b0)     begin n_failed++; $display("[TB] FAIL reset_busy got=%b exp=0", BUSY); end
        if (CFG_CNT !== 8'h00) begin n_failed++; $display("[TB] FAIL reset_cnt got=%h exp=00", CFG_CNT); end
        if (DIN_READY !== 1'b1) begin n_failed++; $display("[TB] FAIL reset_ready got=%b exp=1", DIN_READY); end
        if (ERR_CHK !== 1'b0)  begin n_failed++; $display("[TB] FAIL reset_errchk got=%b exp=0", ERR_CHK); end
        if (ERR_TO !== 1'b0)   begin n_failed++; $display("[TB] FAIL reset_errto got=%b exp=0", ERR_TO); end
        @(posedge CLKEXT);
        #1;
    endtask

    task automatic test_valid_frame();
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h83);
        n_compared += 5;
        if (EN_CONFIG !== 1'b1) begin n_failed++; $display("[TB] FAIL valid_en got=%b exp=1", EN_CONFIG); end
        if (DA !== exp_da)      begin n_failed++; $display("[TB] FAIL valid_da got=%h exp=%h", DA, exp_da); end
        if (DB !== exp_db)      begin n_failed++; $display("[TB] FAIL valid_db got=%h exp=%h", DB, exp_db); end
        if (CFG_CNT !== exp_cnt) begin n_failed++; $display("[TB] FAIL valid_cnt got=%h exp=%h", CFG_CNT, exp_cnt); end
        if (DIN_READY !== 1'b0) begin n_failed++; $display("[TB] FAIL valid_ready got=%b exp=0", DIN_READY); end
        drive_idle(1);
        n_compared += 3;
        if (EN_CONFIG !== 1'b0) begin n_failed++; $display("[TB] FAIL valid_en_pulse got=%b exp=0", EN_CONFIG); end
        if (DA !== exp_da)      begin n_failed++; $display("[TB] FAIL valid_da_hold got=%h exp=%h", DA, exp_da); end
        if (BUSY !== 1'b0)      begin n_failed++; $display("[TB] FAIL valid_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_bad_checksum();
        logic acc;
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        drive_cycle(1'b1, 8'h84, 1'b0, acc);
        n_compared += 4;
        if (ERR_CHK !== exp_err_chk) begin n_failed++; $display("[TB] FAIL badchk_err got=%b exp=%b", ERR_CHK, exp_err_chk); end
        if (EN_CONFIG !== 1'b0)      begin n_failed++; $display("[TB] FAIL badchk_en got=%b exp=0", EN_CONFIG); end
        if (DA !== exp_da)           begin n_failed++; $display("[TB] FAIL badchk_da got=%h exp=%h", DA, exp_da); end
        if (DB !== exp_db)           begin n_failed++; $display("[TB] FAIL badchk_db got=%h exp=%h", DB, exp_db); end
        drive_cycle(1'b0, 8'h00, 1'b1, acc);
        n_compared++;
        if (ERR_CHK !== exp_err_chk) begin n_failed++; $display("[TB] FAIL badchk_clr got=%b exp=%b", ERR_CHK, exp_err_chk); end
        // clear and a new checksum error in the same cycle: the error stays
        send_byte(8'hA5);
        send_byte(8'h34);
        send_byte(8'h12);
        drive_cycle(1'b1, 8'h84, 1'b1, acc);
        n_compared++;
        if (ERR_CHK !== exp_err_chk) begin n_failed++; $display("[TB] FAIL badchk_setwins got=%b exp=%b", ERR_CHK, exp_err_chk); end
        drive_cycle(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic test_timeout();
        logic acc;
        send_byte(8'hA5);
        send_byte(8'h34);
        drive_idle(TO - 1);
        n_compared += 2;
        if (ERR_TO !== exp_err_to) begin n_failed++; $display("[TB] FAIL to_early got=%b exp=%b", ERR_TO, exp_err_to); end
        if (BUSY !== exp_busy())   begin n_failed++; $display("[TB] FAIL to_early_busy got=%b exp=%b", BUSY, exp_busy()); end
        drive_idle(1);
        n_compared += 2;
        if (ERR_TO !== exp_err_to) begin n_failed++; $display("[TB] FAIL to_flag got=%b exp=%b", ERR_TO, exp_err_to); end
        if (BUSY !== exp_busy())   begin n_failed++; $display("[TB] FAIL to_busy got=%b exp=%b", BUSY, exp_busy()); end
        // checksum of 56/78 under sync A5 is 8B
        send_byte(8'hA5);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h8B);
        n_compared += 3;
        if (EN_CONFIG !== exp_en) begin n_failed++; $display("[TB] FAIL to_recover_en got=%b exp=%b", EN_CONFIG, exp_en); end
        if (DA !== exp_da)        begin n_failed++; $display("[TB] FAIL to_recover_da got=%h exp=%h", DA, exp_da); end
        if (DB !== exp_db)        begin n_failed++; $display("[TB] FAIL to_recover_db got=%h exp=%h", DB, exp_db); end
        drive_cycle(1'b0, 8'h00, 1'b1, acc);
        n_compared++;
        if (ERR_TO !== exp_err_to) begin n_failed++; $display("[TB] FAIL to_clr got=%b exp=%b", ERR_TO, exp_err_to); end
    endtask

    task automatic test_handshake_wins();
        send_byte(8'hA5);
        drive_idle(TO - 1);
        send_byte(8'h11);
        n_compared += 2;
        if (ERR_TO !== exp_err_to) begin n_failed++; $display("[TB] FAIL hswin_errto got=%b exp=%b", ERR_TO, exp_err_to); end
        if (BUSY !== exp_busy())   begin n_failed++; $display("[TB] FAIL hswin_busy got=%b exp=%b", BUSY, exp_busy()); end
        send_byte(8'h22);
        send_byte(8'h96);
        n_compared += 2;
        if (EN_CONFIG !== exp_en) begin n_failed++; $display("[TB] FAIL hswin_en got=%b exp=%b", EN_CONFIG, exp_en); end
        if (DA !== exp_da)        begin n_failed++; $display("[TB] FAIL hswin_da got=%h exp=%h", DA, exp_da); end
    endtask

    task automatic test_backpressure();
        logic acc;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hA6);
        n_compared += 4;
        if (EN_CONFIG !== exp_en)    begin n_failed++; $display("[TB] FAIL bp_en got=%b exp=%b", EN_CONFIG, exp_en); end
        if (DA !== exp_da)           begin n_failed++; $display("[TB] FAIL bp_da got=%h exp=%h", DA, exp_da); end
        if (DB !== exp_db)           begin n_failed++; $display("[TB] FAIL bp_db got=%h exp=%h", DB, exp_db); end
        if (DIN_READY !== exp_ready()) begin n_failed++; $display("[TB] FAIL bp_ready got=%b exp=%b", DIN_READY, exp_ready()); end
        // SYNC offered during COMMIT must be held off
        drive_cycle(1'b1, 8'hA5, 1'b0, acc);
        n_compared++;
        if (BUSY !== exp_busy()) begin n_failed++; $display("[TB] FAIL bp_held got=%b exp=%b", BUSY, exp_busy()); end
        drive_cycle(1'b1, 8'hA5, 1'b0, acc);
        n_compared++;
        if (BUSY !== exp_busy()) begin n_failed++; $display("[TB] FAIL bp_taken got=%b exp=%b", BUSY, exp_busy()); end
        // SYNC inside a frame is payload: A5 ^ 00 ^ 00 = A5
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hA5);
        n_compared += 2;
        if (EN_CONFIG !== exp_en) begin n_failed++; $display("[TB] FAIL bp_syncdata_en got=%b exp=%b", EN_CONFIG, exp_en); end
        if (DA !== exp_da)        begin n_failed++; $display("[TB] FAIL bp_syncdata_da got=%h exp=%h", DA, exp_da); end
    endtask

    task automatic test_random();
        offer_t offers[$];
        offer_t o;
        logic acc;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] ck;
        int kind;
        int cyc;
        cyc = 0;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            lo = 8'($urandom);
            hi = 8'($urandom);
            ck = 8'hA5 ^ lo ^ hi;
            if ($urandom_range(0, 3) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
            if (kind < 2) begin
                offers.push_back('{1'b1, 8'($urandom), 1'b0});
            end else begin
                offers.push_back('{1'b1, 8'hA5, 1'b0});
                offers.push_back('{1'b1, lo, 1'b0});
                if (kind == 9) begin
                    for (int g = 0; g < TO + 1; g++) offers.push_back('{1'b0, 8'h00, 1'b0});
                end
                offers.push_back('{1'b1, hi, 1'b0});
                offers.push_back('{1'b1, ck, 1'b0});
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                offers.push_back('{1'b0, 8'h00, 1'b0});
        end
        foreach (offers[i]) begin
            o = offers[i];
            o.clr = ($urandom_range(0, 15) == 0);
            do begin
                drive_cycle(o.v, o.d, o.clr, acc);
                cyc++;
                n_compared += 8;
                if (EN_CONFIG !== exp_en)      begin n_failed++; $display("[TB] FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, EN_CONFIG, exp_en); end
                if (DA !== exp_da)             begin n_failed++; $display("[TB] FAIL rnd_da cyc=%0d got=%h exp=%h", cyc, DA, exp_da); end
                if (DB !== exp_db)             begin n_failed++; $display("[TB] FAIL rnd_db cyc=%0d got=%h exp=%h", cyc, DB, exp_db); end
                if (CFG_CNT !== exp_cnt)       begin n_failed++; $display("[TB] FAIL rnd_cnt cyc=%0d got=%h exp=%h", cyc, CFG_CNT, exp_cnt); end
                if (BUSY !== exp_busy())       begin n_failed++; $display("[TB] FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, BUSY, exp_busy()); end
                if (DIN_READY !== exp_ready()) begin n_failed++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, DIN_READY, exp_ready()); end
                if (ERR_CHK !== exp_err_chk)   begin n_failed++; $display("[TB] FAIL rnd_errchk cyc=%0d got=%b exp=%b", cyc, ERR_CHK, exp_err_chk); end
                if (ERR_TO !== exp_err_to)     begin n_failed++; $display("[TB] FAIL rnd_errto cyc=%0d got=%b exp=%b", cyc, ERR_TO, exp_err_to); end
                o.clr = 1'b0;
            end while (o.v && !acc && cyc < 5000);
        end
    endtask

    task automatic test_mid_frame_reset();
        send_byte(8'hA5);
        send_byte(8'h34);
        DIN_VALID = 1'b0;
        RST_N = 1'b0;
        #2;
        n_compared += 5;
        if (DA !== 8'h80)       begin n_failed++; $display("[TB] FAIL mrst_da got=%h exp=80", DA); end
        if (DB !== 8'h22)       begin n_failed++; $display("[TB] FAIL mrst_db got=%h exp=22", DB); end
        if (BUSY !== 1'b0)      begin n_failed++; $display("[TB] FAIL mrst_busy got=%b exp=0", BUSY); end
        if (CFG_CNT !== 8'h00)  begin n_failed++; $display("[TB] FAIL mrst_cnt got=%h exp=00", CFG_CNT); end
        if (EN_CONFIG !== 1'b0) begin n_failed++; $display("[TB] FAIL mrst_en got=%b exp=0", EN_CONFIG); end
        @(posedge CLKEXT);
        #1;
        RST_N = 1'b1;
        model_reset();
        send_byte(8'h12);
        send_byte(8'h83);
        drive_idle(1);
        n_compared += 3;
        if (EN_CONFIG !== 1'b0) begin n_failed++; $display("[TB] FAIL mrst_noen got=%b exp=0", EN_CONFIG); end
        if (DA !== exp_da)      begin n_failed++; $display("[TB] FAIL mrst_da_hold got=%h exp=%h", DA, exp_da); end
        if (CFG_CNT !== exp_cnt) begin n_failed++; $display("[TB] FAIL mrst_cnt_hold got=%h exp=%h", CFG_CNT, exp_cnt); end
    endtask

    initial begin
        model_reset();
        $display("[TB] ssfr_cfg_loader bench start");
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_timeout();
        test_handshake_wins();
        test_backpressure();
        test_random();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
